// File: rtl/alu_fns_pkg.sv
// ALU function and funct7 control encodings shared between the decode stage and the alu.
package ALU_FNS;

    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } alu_fn_t;

    typedef enum logic {
        ADD_SRL = 1'b0,
        SUB_SRA = 1'b1
    } funct7_t;

endpackage

// File: rtl/decode_stage_pkg.sv
// RV32I decode types: opcode constants, operand selects and the decoded payload.
package RV32I_DEC;
    import ALU_FNS::*;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_t;

    typedef struct packed {
        alu_fn_t          fn;
        funct7_t          funct7;
        a_sel_t           a_sel;
        b_sel_t           b_sel;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rd_we;
        logic             illegal;
        logic [XLEN-1:0]  pc;
    } dec_t;

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Purpose: combinational RV32I instruction word to dec_t payload mapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns the handshake.
module instr_decoder
    import ALU_FNS::*;
    import RV32I_DEC::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_t            dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        ill;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'd0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // Shift-immediates carry only the shamt; the funct7 bits select SRL vs SRA instead.
    assign imm_sh = {27'd0, instr[24:20]};

    always_comb begin
        dec         = '0;
        dec.fn      = ADD_SUB;
        dec.funct7  = ADD_SRL;
        dec.a_sel   = A_RS1;
        dec.b_sel   = B_RS2;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.pc      = pc;
        ill         = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec.fn     = alu_fn_t'(funct3);
                dec.funct7 = instr[30] ? SUB_SRA : ADD_SRL;
                dec.rd_we  = 1'b1;
                ill        = !((f7 == F7_BASE) ||
                               ((f7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                dec.fn     = alu_fn_t'(funct3);
                dec.funct7 = ((funct3 == 3'b101) && instr[30]) ? SUB_SRA : ADD_SRL;
                dec.b_sel  = B_IMM;
                dec.imm    = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? imm_sh : imm_i;
                dec.rd_we  = 1'b1;
                ill        = ((funct3 == 3'b001) && (f7 != F7_BASE)) ||
                             ((funct3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OPC_LOAD: begin
                dec.b_sel = B_IMM;
                dec.imm   = imm_i;
                dec.rd_we = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel = B_IMM;
                dec.imm   = imm_s;
            end
            OPC_LUI: begin
                dec.a_sel = A_ZERO;
                dec.b_sel = B_IMM;
                dec.imm   = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel = A_PC;
                dec.b_sel = B_IMM;
                dec.imm   = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_JAL: begin
                dec.a_sel = A_PC;
                dec.b_sel = B_IMM;
                dec.imm   = imm_j;
                dec.rd_we = 1'b1;
            end
            OPC_JALR: begin
                dec.b_sel = B_IMM;
                dec.imm   = imm_i;
                dec.rd_we = 1'b1;
                ill       = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec.funct7 = SUB_SRA;
                    3'b100, 3'b101: dec.fn     = SLT;
                    3'b110, 3'b111: dec.fn     = SLTU;
                    default:        ill        = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            dec.fn     = ADD_SUB;
            dec.funct7 = ADD_SRL;
            dec.rd_we  = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.rd_we = 1'b0;
        end
        dec.illegal = ill;
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: registered RV32I decode between fetch and alu; DECODE_SKID_EN adds a one-entry skid.
// Latency: 1 cycle accept-to-out_valid, 1 instruction/cycle; flush and async reset clear all state.
// Backpressure: payload held while out_valid && !out_ready; in_ready registered with skid, else combinational.
module decode_stage
    import ALU_FNS::*;
    import RV32I_DEC::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_fn_t          out_fn,
    output funct7_t          out_funct7,
    output a_sel_t           out_a_sel,
    output b_sel_t           out_b_sel,
    output logic [WIDTH-1:0] out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_rd_we,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_illegal
);

    dec_t dec_n;
    dec_t out_q;
    logic out_vld_q;

    instr_decoder u_instr_decoder (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec_n)
    );

`ifdef DECODE_SKID_EN
    dec_t skid_q;
    logic skid_vld_q;
    logic in_rdy_q;
    logic accept;
    logic load_out;

    assign in_ready = in_rdy_q;
    assign accept   = in_valid && in_rdy_q;
    assign load_out = !out_vld_q || out_ready;

    // in_rdy_q tracks "skid empty" so a stall can absorb exactly one more instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            in_rdy_q   <= 1'b1;
        end else if (flush) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else if (load_out) begin
            if (skid_vld_q) begin
                out_q      <= skid_q;
                out_vld_q  <= 1'b1;
                skid_vld_q <= 1'b0;
                in_rdy_q   <= 1'b1;
            end else begin
                out_vld_q <= accept;
                if (accept) begin
                    out_q <= dec_n;
                end
            end
        end else if (accept) begin
            skid_q     <= dec_n;
            skid_vld_q <= 1'b1;
            in_rdy_q   <= 1'b0;
        end
    end
`else
    assign in_ready = !out_vld_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_vld_q <= 1'b0;
        end else if (in_ready) begin
            out_vld_q <= in_valid;
            if (in_valid) begin
                out_q <= dec_n;
            end
        end
    end
`endif

    assign out_valid   = out_vld_q;
    assign out_fn      = out_q.fn;
    assign out_funct7  = out_q.funct7;
    assign out_a_sel   = out_q.a_sel;
    assign out_b_sel   = out_q.b_sel;
    assign out_imm     = out_q.imm;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;
    assign out_pc      = out_q.pc;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage with an in-order scoreboard on the output handshake.
module tb_decode_stage;
    import ALU_FNS::*;
    import RV32I_DEC::*;

`ifdef DECODE_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    alu_fn_t     out_fn;
    funct7_t     out_funct7;
    a_sel_t      out_a_sel;
    b_sel_t      out_b_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_pc;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fn      (out_fn),
        .out_funct7  (out_funct7),
        .out_a_sel   (out_a_sel),
        .out_b_sel   (out_b_sel),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];
    dec_t sb_q [$];
    dec_t exp_cur;
    dec_t mon_exp;
    dec_t mon_got;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
        end
    endtask

    function automatic dec_t mk(input alu_fn_t fn, input funct7_t f7, input a_sel_t a,
                                input b_sel_t b, input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                                input logic ill);
        dec_t d;
        d         = '0;
        d.fn      = fn;
        d.funct7  = f7;
        d.a_sel   = a;
        d.b_sel   = b;
        d.imm     = imm;
        d.rs1     = rs1;
        d.rs2     = rs2;
        d.rd      = rd;
        d.rd_we   = we;
        d.illegal = ill;
        return d;
    endfunction

    // Scoreboard: push on accepted input, pop on output transfer; flush/reset discard everything held.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got output pc 0x%08h required no output", out_pc);
                end else begin
                    mon_exp = sb_q.pop_front();
                    mon_got = '0;
                    mon_got.fn      = out_fn;
                    mon_got.funct7  = out_funct7;
                    mon_got.a_sel   = out_a_sel;
                    mon_got.b_sel   = out_b_sel;
                    mon_got.imm     = out_imm;
                    mon_got.rs1     = out_rs1;
                    mon_got.rs2     = out_rs2;
                    mon_got.rd      = out_rd;
                    mon_got.rd_we   = out_rd_we;
                    mon_got.illegal = out_illegal;
                    mon_got.pc      = out_pc;
                    if (mon_got !== mon_exp) begin
                        fails++;
                        $display("FAIL sb_payload pc 0x%08h: got 0x%022h required 0x%022h",
                                 mon_exp.pc, mon_got, mon_exp);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(exp_cur);
        end
    end

    task automatic send(input int idx, output int waited);
        in_instr   = tbl[idx].instr;
        in_pc      = 32'h1000 + 32'(idx * 4);
        exp_cur    = tbl[idx].exp;
        exp_cur.pc = in_pc;
        in_valid   = 1'b1;
        waited     = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited >= 40) begin
                tests++;
                fails++;
                $display("FAIL send_timeout idx %0d: got in_ready 0 required 1 within 40 cycles", idx);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        chk(nm, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int w;
        tbl[0]  = '{32'h002081B3, mk(ADD_SUB, ADD_SRL, A_RS1,  B_RS2, 32'h0,        5'd1, 5'd2,  5'd3,  1'b1, 1'b0)};
        tbl[1]  = '{32'h402081B3, mk(ADD_SUB, SUB_SRA, A_RS1,  B_RS2, 32'h0,        5'd1, 5'd2,  5'd3,  1'b1, 1'b0)};
        tbl[2]  = '{32'h40335293, mk(SRL_SRA, SUB_SRA, A_RS1,  B_IMM, 32'h3,        5'd6, 5'd3,  5'd5,  1'b1, 1'b0)};
        tbl[3]  = '{32'hC0000093, mk(ADD_SUB, ADD_SRL, A_RS1,  B_IMM, 32'hFFFFFC00, 5'd0, 5'd0,  5'd1,  1'b1, 1'b0)};
        tbl[4]  = '{32'h00000000, mk(ADD_SUB, ADD_SRL, A_RS1,  B_RS2, 32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 1'b1)};
        tbl[5]  = '{32'h0000206B, mk(ADD_SUB, ADD_SRL, A_RS1,  B_RS2, 32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 1'b1)};
        tbl[6]  = '{32'h123452B7, mk(ADD_SUB, ADD_SRL, A_ZERO, B_IMM, 32'h12345000, 5'd8, 5'd3,  5'd5,  1'b1, 1'b0)};
        tbl[7]  = '{32'h00001017, mk(ADD_SUB, ADD_SRL, A_PC,   B_IMM, 32'h00001000, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0)};
        tbl[8]  = '{32'h00208463, mk(ADD_SUB, SUB_SRA, A_RS1,  B_RS2, 32'h8,        5'd1, 5'd2,  5'd8,  1'b0, 1'b0)};
        tbl[9]  = '{32'hFE20EEE3, mk(SLTU,    ADD_SRL, A_RS1,  B_RS2, 32'hFFFFFFFC, 5'd1, 5'd2,  5'd29, 1'b0, 1'b0)};
        tbl[10] = '{32'h00002063, mk(ADD_SUB, ADD_SRL, A_RS1,  B_RS2, 32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 1'b1)};
        tbl[11] = '{32'h0020A623, mk(ADD_SUB, ADD_SRL, A_RS1,  B_IMM, 32'd12,       5'd1, 5'd2,  5'd12, 1'b0, 1'b0)};
        tbl[12] = '{32'h010000EF, mk(ADD_SUB, ADD_SRL, A_PC,   B_IMM, 32'd16,       5'd0, 5'd16, 5'd1,  1'b1, 1'b0)};
        tbl[13] = '{32'h000090E7, mk(ADD_SUB, ADD_SRL, A_RS1,  B_IMM, 32'h0,        5'd1, 5'd0,  5'd1,  1'b0, 1'b1)};
        tbl[14] = '{32'h40109093, mk(ADD_SUB, ADD_SRL, A_RS1,  B_IMM, 32'h1,        5'd1, 5'd1,  5'd1,  1'b0, 1'b1)};
        tbl[15] = '{32'h402091B3, mk(ADD_SUB, ADD_SRL, A_RS1,  B_RS2, 32'h0,        5'd1, 5'd2,  5'd3,  1'b0, 1'b1)};
        tbl[16] = '{32'hFF832283, mk(ADD_SUB, ADD_SRL, A_RS1,  B_IMM, 32'hFFFFFFF8, 5'd6, 5'd24, 5'd5,  1'b1, 1'b0)};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        exp_cur   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fn",        32'(out_fn), 32'(ADD_SUB));
        chk("rst_funct7",    32'(out_funct7), 32'(ADD_SRL));
        chk("rst_a_sel",     32'(out_a_sel), 32'(A_RS1));
        chk("rst_b_sel",     32'(out_b_sel), 32'(B_RS2));
        chk("rst_illegal",   32'(out_illegal), 32'd0);
        chk("rst_imm",       out_imm, 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream with the sink always ready: no bubbles, 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            send(i, w);
            chk($sformatf("tbl%0d_wait", i), 32'(w), 32'd0);
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'd1);
        end
        drain("tbl_drain");

        // Back-pressure: three instructions against a stalled sink.
        out_ready = 1'b0;
        send(0, w);
        chk("bp_in_ready_after1", 32'(in_ready), 32'(SKID));
`ifdef DECODE_SKID_EN
        send(1, w);
        chk("bp_in_ready_after2", 32'(in_ready), 32'd0);
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_pc", out_pc, 32'h1000);
        end
        fork
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
`ifndef DECODE_SKID_EN
        send(1, w);
`endif
        send(2, w);
        drain("bp_drain");

        // Flush coincident with a new input: everything held and the new word vanish.
        out_ready = 1'b0;
        send(3, w);
`ifdef DECODE_SKID_EN
        send(4, w);
`endif
        in_instr = tbl[5].instr;
        in_pc    = 32'h2000;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("flush_quiet", 32'(out_valid), 32'd0);
        end
        chk("flush_sb_empty", 32'(sb_q.size()), 32'd0);

        // Async reset mid-stream clears the held payload without a clock edge.
        out_ready = 1'b0;
        send(14, w);
        chk("pre_rst_illegal", 32'(out_illegal), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_illegal",   32'(out_illegal), 32'd0);
        chk("arst_imm",       out_imm, 32'd0);
        chk("arst_rd",        32'(out_rd), 32'd0);
        chk("arst_in_ready",  32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage sitting between instruction fetch and the `alu`. It converts a fetched instruction word into the `alu_fn_t` / `funct7_t` controls the ALU consumes, plus operand selects, the immediate, register indices and an illegal-instruction flag. It uses a valid/ready handshake on both sides and supports flush, stall and back-pressure.

## Interface
- `WIDTH`, 32: datapath and PC width; only 32 is supported.
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: discard all held and incoming instructions.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `in_instr` in 32 / `in_pc` in WIDTH: instruction word and its PC.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `out_fn` out `alu_fn_t`, `out_funct7` out `funct7_t`: ALU controls.
- `out_a_sel` out `a_sel_t` {A_RS1, A_PC, A_ZERO}; `out_b_sel` out `b_sel_t` {B_RS2, B_IMM}.
- `out_imm` out WIDTH: sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5: register indices.
- `out_rd_we` out 1: destination register write enable.
- `out_pc` out WIDTH: PC passed through.
- `out_illegal` out 1: unsupported or reserved encoding.

## Operation
- `alu_fn_t` encoding equals funct3: ADD_SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL_SRA=5, OR=6, AND=7.
- OP (0110011): fn=funct3; funct7=SUB_SRA if instr[30], else ADD_SRL; A_RS1/B_RS2; rd_we=1.
  - Legal only with instr[31:25]=0000000, or =0100000 with funct3 000 or 101.
- OP-IMM (0010011): fn=funct3; B_IMM, I-type immediate; rd_we=1.
  - funct7=SUB_SRA only when funct3=101 and instr[30]=1; ADDI never subtracts.
  - funct3=001 requires instr[31:25]=0; funct3=101 requires 0000000 or 0100000; otherwise illegal.
- LOAD / STORE: fn=ADD_SUB, ADD_SRL, B_IMM with I-/S-immediate. rd_we is 1 for LOAD and 0 for STORE.
- LUI: A_ZERO, B_IMM, U-immediate. AUIPC: A_PC, B_IMM, U-immediate. Both ADD_SUB/ADD_SRL, rd_we=1.
- JAL: A_PC, J-immediate. JALR: A_RS1, I-immediate, funct3 must be 000. Both ADD_SUB/ADD_SRL, rd_we=1.
- BRANCH: B_RS2, B-immediate in `out_imm`, rd_we=0.
  - BEQ/BNE → ADD_SUB/SUB_SRA; BLT/BGE → SLT; BLTU/BGEU → SLTU.
  - funct3 010/011 are illegal.
- Any other opcode or illegal case: out_illegal=1, fn=ADD_SUB, funct7=ADD_SRL, rd_we=0; the remaining fields are still decoded.
- rd_we is forced to 0 when rd=0.

## Timing
- Latency: 1 cycle from an accepted input (`in_valid && in_ready`) to `out_valid`.
- Throughput: 1 instruction per cycle.
- Handshake rules:
  - The output payload is held stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer or a flush.
- Flush: `out_valid`, and any skid entry, are 0 on the next edge. An input presented in the same cycle is dropped; flush wins over capture.
- Reset values: `out_valid`=0; all payload registers 0, so fn=ADD_SUB, funct7=ADD_SRL, A_RS1, B_RS2, illegal=0. Asserting `rst_n` low clears these immediately, including mid-stream.
- Simultaneous accept and drain in the same cycle: the new instruction replaces the old one with no bubble.

## Configuration
- `DECODE_SKID_EN` defined:
  - A one-entry skid buffer is added and `in_ready` is registered: it is 1 whenever the skid is empty, and it resets to 1.
  - One instruction accepted during a stall is parked in the skid. The skid drains first once `out_ready` returns.
- `DECODE_SKID_EN` undefined:
  - No skid buffer.
  - `in_ready` = `!out_valid || out_ready`, which is combinational from `out_ready`.

## Structure
- `alu_fn_t` and `funct7_t` are reused from `ALU_FNS`.
- New package `RV32I_DEC` holds: opcode constants, `a_sel_t`, `b_sel_t`, and a packed `dec_t` payload struct used by both the output register and the skid.
- One combinational sub-module, `instr_decoder`: maps `in_instr` to `dec_t`.
- The top level owns the handshake, the skid and flush.

## Test plan
- Field decode: `0x002081B3` (add x3,x1,x2) → next cycle out_valid=1, fn=ADD_SUB, funct7=ADD_SRL, rs1=1, rs2=2, rd=3, rd_we=1.
- Subtract and arithmetic shift:
  - `0x402081B3` → funct7=SUB_SRA.
  - `0x40335293` (srai x5,x6,3) → fn=SRL_SRA, funct7=SUB_SRA, B_IMM, imm=3.
- ADDI sign extension: `0xC0000093` (addi x1,x0,-1024) → imm=0xFFFFFC00, funct7=ADD_SRL.
- Illegal encodings: `0x00000000` → out_illegal=1, rd_we=0; `0x0000206B` → out_illegal=1.
- Back-pressure: three instructions sent with out_ready=0 → no loss and order preserved.
  - Skid build: in_ready falls after two instructions are accepted.
  - Non-skid build: in_ready falls after one.
- Flush and reset:
  - flush coincident with in_valid → out_valid=0 next cycle and the instruction never appears.
  - rst_n low mid-stream → out_valid=0 with no clock edge.
